// File: rtl/halt_mem_dump_tx.sv
// Post-halt data-memory dump: reads DUMP_WORDS words and streams addr/hi/lo bytes as 8N1 serial.
// Optional XOR trailer byte when DUMP_CHECKSUM_EN is defined.
module halt_mem_dump_tx #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 8,
   parameter int DUMP_WORDS   = 10,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              do_halt,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   // state  | meaning
   // IDLE   | waiting for do_halt falling edge
   // RD     | read strobe at current word address
   // RDW    | capture read data
   // LOAD   | pick byte into shift register, start bit goes out next
   // START  | start bit (low)
   // DATA   | 8 data bits, LSB first
   // STOP   | stop bit (high)
   // NEXT   | advance byte / word / finish
   // FIN    | done pulse
   typedef enum logic [3:0] {
      S_IDLE, S_RD, S_RDW, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT, S_FIN
   } state_t;

   localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DUMP_WORDS - 1);

   state_t              state_q, state_d;
   logic                halt_q, halt_d;
   logic                init_q, init_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [ADDR_W:0]     cnt_nxt;
   logic [1:0]          idx_q, idx_d;
   logic [2:0]          bit_q, bit_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [7:0]          sh_q, sh_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic                tx_q, tx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          byte_sel;
   logic                start;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   // init_q masks the first cycle after reset so a low do_halt at release is not seen as an edge.
   assign start   = ~init_q & halt_q & ~do_halt;
   assign cnt_nxt = cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      halt_d   = do_halt;
      init_d   = 1'b0;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      bit_d    = bit_q;
      tmr_d    = tmr_q;
      sh_d     = sh_q;
      word_d   = word_q;
      tx_d     = tx_q;
      addr_d   = addr_q;
      byte_sel = word_q[7:0];
`ifdef DUMP_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (idx_q)
         2'd0:    byte_sel = 8'(cnt_q);
         2'd1:    byte_sel = word_q[15:8];
         2'd2:    byte_sel = word_q[7:0];
`ifdef DUMP_CHECKSUM_EN
         default: byte_sel = csum_q;
`else
         default: byte_sel = word_q[7:0];
`endif
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD;
               cnt_d   = '0;
               idx_d   = 2'd0;
               addr_d  = '0;
`ifdef DUMP_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         S_RD:  state_d = S_RDW;
         S_RDW: begin
            word_d  = mem_rdata;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            sh_d    = byte_sel;
            tx_d    = 1'b0;
            tmr_d   = TMR_LOAD;
            state_d = S_START;
`ifdef DUMP_CHECKSUM_EN
            if (idx_q != 2'd3) csum_d = csum_q ^ byte_sel;
`endif
         end
         S_START: begin
            if (tmr_q == '0) begin
               state_d = S_DATA;
               tx_d    = sh_q[0];
               tmr_d   = TMR_LOAD;
               bit_d   = 3'd0;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_DATA: begin
            if (tmr_q == '0) begin
               tmr_d = TMR_LOAD;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  sh_d  = {1'b0, sh_q[7:1]};
                  tx_d  = sh_q[1];
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_STOP: begin
            if (tmr_q == '0) state_d = S_NEXT;
            else             tmr_d   = tmr_q - 1'b1;
         end
         S_NEXT: begin
            if (idx_q < 2'd2) begin
               idx_d   = idx_q + 2'd1;
               state_d = S_LOAD;
            end else if (idx_q == 2'd2 && cnt_q < LAST_CNT) begin
               cnt_d   = cnt_nxt;
               idx_d   = 2'd0;
               addr_d  = cnt_nxt[ADDR_W-1:0];
               state_d = S_RD;
`ifdef DUMP_CHECKSUM_EN
            end else if (idx_q == 2'd2) begin
               idx_d   = 2'd3;
               state_d = S_LOAD;
`endif
            end else begin
               state_d = S_FIN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         halt_q  <= 1'b1;
         init_q  <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         bit_q   <= 3'd0;
         tmr_q   <= '0;
         sh_q    <= 8'h00;
         word_q  <= '0;
         tx_q    <= 1'b1;
         addr_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         init_q  <= init_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         tmr_q   <= tmr_d;
         sh_q    <= sh_d;
         word_q  <= word_d;
         tx_q    <= tx_d;
         addr_q  <= addr_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign tx       = tx_q;
   assign mem_addr = addr_q;
   assign mem_re   = (state_q == S_RD);
   assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done     = (state_q == S_FIN);

endmodule

// File: tb/tb_halt_mem_dump_tx.sv
// Directed bench for halt_mem_dump_tx: memory model, serial decoder, per-scenario tasks.
module tb_halt_mem_dump_tx;

`ifdef DUMP_CHECKSUM_EN
   localparam int NW = 2;
   localparam int CS = 1;
`else
   localparam int NW = 10;
   localparam int CS = 0;
`endif
   localparam int CPB      = 16;
   localparam int NB       = 3*NW + CS;
   localparam int WORD_CYC = 3*(10*CPB+2) + 2;
   localparam int BUSY_EXP = NW*WORD_CYC + CS*(10*CPB+2);
   localparam int WM       = (NW > 4) ? 4 : NW-1;

   logic        CLK = 1'b0;
   logic        rst = 1'b0;
   logic        do_halt = 1'b0;
   logic        mem_re;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata = 16'h0000;
   logic        tx, busy, done;

   logic [15:0] mem [0:255];
   logic [7:0]  byte_q [$];
   logic [7:0]  addr_q [$];
   int          busy_cycles = 0;
   int          done_cnt = 0;
   int          frame_bad = 0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          t_drop = 0;

   halt_mem_dump_tx #(.DATA_W(16), .ADDR_W(8), .DUMP_WORDS(NW), .CLKS_PER_BIT(CPB)) dut (
      .CLK(CLK), .rst(rst), .do_halt(do_halt), .mem_re(mem_re), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .tx(tx), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   always @(posedge CLK) if (mem_re) mem_rdata <= mem[mem_addr];

   always @(negedge CLK) begin
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (mem_re) addr_q.push_back(mem_addr);
   end

   // Serial decoder: every one of the CPB samples of each bit must agree; reset aborts a frame.
   always begin
      logic [9:0] frame;
      logic       lvl;
      bit         ok, abort;
      @(negedge CLK);
      if (rst && tx === 1'b0) begin
         ok = 1; abort = 0; frame = '0; lvl = 1'b0;
         for (int b = 0; b < 10 && !abort; b++) begin
            for (int s = 0; s < CPB; s++) begin
               if (!(b == 0 && s == 0)) @(negedge CLK);
               if (!rst) begin abort = 1; break; end
               if (s == 0) lvl = tx;
               else if (tx !== lvl) ok = 0;
            end
            frame[b] = lvl;
         end
         if (!abort) begin
            byte_q.push_back(frame[8:1]);
            if (!ok || frame[0] !== 1'b0 || frame[9] !== 1'b1) frame_bad++;
         end
      end
   end

   function automatic logic [7:0] exp_byte(input int k);
      int w;
      w = k / 3;
      if (k >= 3*NW) return 8'h01;
      case (k % 3)
         0:       return 8'(w);
         1:       return mem[w][15:8];
         default: return mem[w][7:0];
      endcase
   endfunction

   task automatic raise_halt();
      @(posedge CLK); #1 do_halt = 1'b1;
      repeat (3) @(posedge CLK);
   endtask

   task automatic drop_halt();
      @(posedge CLK); #1 do_halt = 1'b0;
      t_drop = cyc;
   endtask

   task automatic wait_done(input int target, input string nm);
      int n;
      n = 0;
      while (done_cnt < target && n < 20000) begin @(negedge CLK); n++; end
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("FAIL %s_timeout: done count %0d, required %0d", nm, done_cnt, target);
      end
      repeat (5) @(negedge CLK);
   endtask

   task automatic test_reset();
      repeat (5) @(posedge CLK);
      #1;
      checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (mem_re !== 1'b0)   begin errors++; $display("FAIL rst_mem_re: got %b want 0", mem_re); end
      checks++; if (mem_addr !== 8'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr); end
      @(posedge CLK); #1 rst = 1'b1;
      repeat (1000) @(negedge CLK);
      checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL idle_mem_re: got %0d reads want 0", addr_q.size()); end
      checks++; if (busy_cycles != 0)   begin errors++; $display("FAIL idle_busy: got %0d cycles want 0", busy_cycles); end
      checks++; if (byte_q.size() != 0) begin errors++; $display("FAIL idle_tx: got %0d bytes want 0", byte_q.size()); end
   endtask

   task automatic test_basic_dump();
      int a0, b0, d0, bc0, fb0, n;
      raise_halt();
      a0 = addr_q.size(); b0 = byte_q.size(); d0 = done_cnt; bc0 = busy_cycles; fb0 = frame_bad;
      drop_halt();
      n = 0;
      do begin @(negedge CLK); n++; end while (tx !== 1'b0 && n < 100);
      checks++; if (cyc - t_drop != 4) begin errors++; $display("FAIL first_low_latency: got %0d want 4", cyc - t_drop); end
      wait_done(d0 + 1, "basic");
      checks++; if (byte_q.size() - b0 != NB) begin errors++; $display("FAIL basic_byte_count: got %0d want %0d", byte_q.size() - b0, NB); end
      for (int k = 0; k < NB && b0 + k < byte_q.size(); k++) begin
         checks++;
         if (byte_q[b0+k] !== exp_byte(k)) begin
            errors++; $display("FAIL basic_byte[%0d]: got %h want %h", k, byte_q[b0+k], exp_byte(k));
         end
      end
      checks++; if (addr_q.size() - a0 != NW) begin errors++; $display("FAIL basic_read_count: got %0d want %0d", addr_q.size() - a0, NW); end
      for (int k = 0; k < NW && a0 + k < addr_q.size(); k++) begin
         checks++;
         if (addr_q[a0+k] !== 8'(k)) begin errors++; $display("FAIL basic_addr[%0d]: got %h want %h", k, addr_q[a0+k], 8'(k)); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
      checks++; if (busy_cycles - bc0 != BUSY_EXP) begin errors++; $display("FAIL basic_busy_time: got %0d want %0d", busy_cycles - bc0, BUSY_EXP); end
      checks++; if (frame_bad != fb0) begin errors++; $display("FAIL basic_framing: got %0d bad frames want 0", frame_bad - fb0); end
`ifdef DUMP_CHECKSUM_EN
      checks++; if (byte_q[byte_q.size()-1] !== 8'h01) begin errors++; $display("FAIL checksum_trailer: got %h want 01", byte_q[byte_q.size()-1]); end
`endif
   endtask

   task automatic test_retrigger();
      int a0, b0, d0, fb0;
      raise_halt();
      a0 = addr_q.size(); b0 = byte_q.size(); d0 = done_cnt; fb0 = frame_bad;
      drop_halt();
      repeat (300) @(posedge CLK);
      #1 do_halt = 1'b1;
      repeat (50) @(posedge CLK);
      #1 do_halt = 1'b0;
      repeat (300) @(posedge CLK);
      #1 do_halt = 1'b1;
      repeat (50) @(posedge CLK);
      #1 do_halt = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL retrig_still_busy: got %b want 1", busy); end
      wait_done(d0 + 1, "retrig");
      repeat (2000) @(negedge CLK);
      checks++; if (byte_q.size() - b0 != NB) begin errors++; $display("FAIL retrig_byte_count: got %0d want %0d", byte_q.size() - b0, NB); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL retrig_done_pulses: got %0d want 1", done_cnt - d0); end
      checks++; if (addr_q.size() - a0 != NW) begin errors++; $display("FAIL retrig_read_count: got %0d want %0d", addr_q.size() - a0, NW); end
      checks++; if (frame_bad != fb0) begin errors++; $display("FAIL retrig_framing: got %0d bad frames want 0", frame_bad - fb0); end
   endtask

   task automatic test_reset_mid();
      int a0, b0, d0;
      raise_halt();
      b0 = byte_q.size();
      drop_halt();
      repeat (1 + WM*WORD_CYC + 3 + CPB + 30) @(posedge CLK);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      #2 rst = 1'b0;
      #1;
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      checks++; if (byte_q.size() - b0 != 3*WM) begin errors++; $display("FAIL mid_bytes_before_rst: got %0d want %0d", byte_q.size() - b0, 3*WM); end
      repeat (5) @(posedge CLK);
      #1 rst = 1'b1;
      a0 = addr_q.size(); b0 = byte_q.size();
      repeat (50) @(negedge CLK);
      checks++; if (addr_q.size() != a0) begin errors++; $display("FAIL mid_no_resume: got %0d reads want 0", addr_q.size() - a0); end
      checks++; if (byte_q.size() != b0) begin errors++; $display("FAIL mid_no_partial: got %0d bytes want 0", byte_q.size() - b0); end
      d0 = done_cnt;
      raise_halt();
      drop_halt();
      wait_done(d0 + 1, "restart");
      checks++; if (addr_q.size() - a0 != NW) begin errors++; $display("FAIL restart_read_count: got %0d want %0d", addr_q.size() - a0, NW); end
      if (addr_q.size() > a0) begin
         checks++; if (addr_q[a0] !== 8'h00) begin errors++; $display("FAIL restart_first_addr: got %h want 00", addr_q[a0]); end
      end
      checks++; if (byte_q.size() - b0 != NB) begin errors++; $display("FAIL restart_byte_count: got %0d want %0d", byte_q.size() - b0, NB); end
      for (int k = 0; k < 3 && b0 + k < byte_q.size(); k++) begin
         checks++;
         if (byte_q[b0+k] !== exp_byte(k)) begin errors++; $display("FAIL restart_byte[%0d]: got %h want %h", k, byte_q[b0+k], exp_byte(k)); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
`ifdef DUMP_CHECKSUM_EN
      mem[0] = 16'hA5A5;
      mem[1] = 16'h0F0F;
`else
      mem[3] = 16'h1234;
`endif
      test_reset();
      test_basic_dump();
      test_retrigger();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/halt_mem_dump_tx.md
Name: halt_mem_dump_tx

Overview:
- Reads data memory after the CPU halts and streams it out serially, so hardware runs can be checked the same way as simulation memory dumps.
- Sits beside CPU:
  - watches `do_halt`;
  - reads through a dedicated read port on the memory module;
  - drives a UART-style TX line (8N1, LSB first) to the board.
- Each word goes out as 3 bytes: address, data[15:8], data[7:0].

Parameters:
- DATA_W, 16, memory word width. Fixed at 16; other values are unsupported.
- ADDR_W, 8, memory address width.
- DUMP_WORDS, 10, number of words dumped, starting at address 0. Range 1..2^ADDR_W.
- CLKS_PER_BIT, 16, CLK cycles per serial bit. Minimum 2.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- do_halt  in  1  CPU halt flag; a falling edge starts a dump.
- mem_re  out  1  read strobe to memory read port.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  read data; valid exactly 1 cycle after mem_re.
- tx  out  1  serial output; idle high.
- busy  out  1  high from dump start until the last stop bit completes.
- done  out  1  1-cycle pulse after the last stop bit.

Behaviour:
- Reset (rst=0, async):
  - tx=1, busy=0, done=0, mem_re=0, mem_addr=0;
  - FSM goes to IDLE; word counter, byte index and bit counters are cleared;
  - do_halt edge-detect register is loaded with 1, so a low do_halt at reset release does not trigger.
- Start detection:
  - do_halt is registered once; start when prev=1 and current=0.
  - Start is accepted only in IDLE. Falling edges while busy are ignored; no queuing.
- FSM states: IDLE, RD, RDW, LOAD, START, DATA, STOP, NEXT, FIN.
  - IDLE: start -> RD, busy=1, addr counter=0.
  - RD: mem_re=1 for 1 cycle, mem_addr=counter -> RDW.
  - RDW: mem_re=0; capture mem_rdata into word register -> LOAD.
  - LOAD: select byte (idx 0=addr, 1=word[15:8], 2=word[7:0]) into shift register -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> NEXT.
  - NEXT:
    - idx<2: idx++ -> LOAD;
    - else if counter<DUMP_WORDS-1: counter++, idx=0 -> RD;
    - else -> FIN.
  - FIN: done=1 for 1 cycle, busy=0 -> IDLE.
- Address byte is counter zero-extended/truncated to 8 bits. Counter is ADDR_W+1 bits wide so DUMP_WORDS=2^ADDR_W does not wrap early.
- Timing:
  - Start edge to first tx low: 4 cycles (edge-detect register, RD, RDW, LOAD).
  - Bytes back-to-back within a word, with 1 NEXT+1 LOAD cycle of idle-high between them.
  - Per word: 3*(10*CLKS_PER_BIT+2)+2 cycles.
- tx is registered (no glitches); mem_addr holds its value outside RD.
- rst asserted mid-byte: tx returns to 1 immediately (async); no partial frame resumes after release.
- do_halt rising while busy: no effect; the dump completes.

Optional Feature:
- DUMP_CHECKSUM_EN defined:
  - after the last word's low byte, NEXT -> LOAD of one extra byte = XOR of all bytes transmitted in this dump;
  - framed 8N1 identically; done pulses after its stop bit.
- Not defined: no trailer; checksum register and logic absent.

Test Plan:
- Reset idle: hold rst=0, then release with do_halt=0 -> tx=1, busy=0, no mem_re for 1000 cycles.
- Basic dump: memory[0..9]=0,1,2,...,9 (mem[3]=16'h1234 override); CLKS_PER_BIT=16; drop do_halt -> decoded bytes 00 00 00, 01 00 01, 02 00 02, 03 12 34, ..., 09 00 09. Also check:
  - mem_re pulses 10 times at addrs 0..9;
  - done pulses once;
  - first tx low exactly 4 cycles after edge.
- Bit timing: sample tx at bit centers -> start=0, stop=1, each level held exactly 16 cycles; total busy time = 10*(3*162+2) cycles.
- Retrigger ignored: toggle do_halt 1->0 twice more during the dump -> exactly 30 bytes total, a single done pulse.
- Reset mid-operation: assert rst during word 4 DATA state -> tx=1 and busy=0 at once; a new do_halt falling edge restarts from address 0.
- Checksum (DUMP_CHECKSUM_EN, DUMP_WORDS=2, mem[0]=16'hA5A5, mem[1]=16'h0F0F) -> bytes 00 A5 A5 01 0F 0F, then trailer 01; done after trailer.
